// File: rtl/i2c_slave.sv
// I2C slave: 7-bit addressed, single-byte register for writes, din-sourced reads.
// Bus pins are synchronized to clk; SDA is only ever pulled low or released.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       op,
  output logic       ack_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ACK_A     = 3'd2,
    RX        = 3'd3,
    ACK_D     = 3'd4,
    TX        = 3'd5,
    MACK      = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_prev_r, sda_prev_r;
  logic scl_s, sda_s, start_s, stop_s, scl_rise_s, scl_fall_s;

  state_t     state_r, state_n;
  logic [3:0] cnt_r, cnt_n;
  logic [7:0] shift_r, shift_n;
  logic [7:0] tx_r, tx_n;
  logic [7:0] dout_r, dout_n;
  logic       busy_r, busy_n;
  logic       done_r, done_n;
  logic       op_r, op_n;
  logic       ack_err_r, ack_err_n;
  logic       sda_oe_r, sda_oe_n;
  logic       sda_lo_r, sda_lo_n;

  // Pin synchronizers plus one clk of history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;

  // Transaction state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      shift_r   <= 8'h00;
      tx_r      <= 8'h00;
      dout_r    <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      op_r      <= 1'b0;
      ack_err_r <= 1'b0;
      sda_oe_r  <= 1'b0;
      sda_lo_r  <= 1'b1;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      shift_r   <= shift_n;
      tx_r      <= tx_n;
      dout_r    <= dout_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      op_r      <= op_n;
      ack_err_r <= ack_err_n;
      sda_oe_r  <= sda_oe_n;
      sda_lo_r  <= sda_lo_n;
    end
  end

  // Next-state logic; bus conditions override any scl edge in the same clk.
  // In ACK states sda_oe_r doubles as the "first fall already seen" flag.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    shift_n   = shift_r;
    tx_n      = tx_r;
    dout_n    = dout_r;
    busy_n    = busy_r;
    done_n    = 1'b0;
    op_n      = op_r;
    ack_err_n = ack_err_r;
    sda_oe_n  = sda_oe_r;
    sda_lo_n  = sda_lo_r;
    if (stop_s) begin
      state_n  = IDLE;
      cnt_n    = 4'd0;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
      sda_lo_n = 1'b1;
    end else if (start_s) begin
      state_n   = ADDR;
      cnt_n     = 4'd0;
      ack_err_n = 1'b0;
      sda_oe_n  = 1'b0;
      sda_lo_n  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s) begin
            shift_n = {shift_r[6:0], sda_s};
            if (cnt_r == 4'd7) begin
              cnt_n = 4'd0;
              if (shift_r[6:0] == SLAVE_ADDR) begin
                state_n = ACK_A;
                op_n    = sda_s;
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT_STOP;
              end
            end else begin
              cnt_n = cnt_r + 4'd1;
            end
          end else begin
            state_n = state_r;
          end
        end
        ACK_A: begin
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_n = 1'b1;
              sda_lo_n = 1'b0;
            end else if (op_r) begin
              tx_n     = din;
              sda_oe_n = 1'b1;
              sda_lo_n = din[7];
              state_n  = TX;
            end else begin
              sda_oe_n = 1'b0;
              sda_lo_n = 1'b1;
              state_n  = RX;
            end
          end else begin
            state_n = state_r;
          end
        end
        RX: begin
          if (scl_rise_s) begin
            shift_n = {shift_r[6:0], sda_s};
            if (cnt_r == 4'd7) begin
              dout_n  = {shift_r[6:0], sda_s};
              cnt_n   = 4'd0;
              state_n = ACK_D;
            end else begin
              cnt_n = cnt_r + 4'd1;
            end
          end else begin
            state_n = state_r;
          end
        end
        ACK_D: begin
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_n = 1'b1;
              sda_lo_n = 1'b0;
            end else begin
              sda_oe_n = 1'b0;
              sda_lo_n = 1'b1;
              done_n   = 1'b1;
              state_n  = RX;
            end
          end else begin
            state_n = state_r;
          end
        end
        TX: begin
          // Entered from MACK with sda released: the first fall presents bit 7
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_n = 1'b1;
              sda_lo_n = tx_r[7];
            end else if (cnt_r == 4'd7) begin
              sda_oe_n = 1'b0;
              sda_lo_n = 1'b1;
              cnt_n    = 4'd0;
              state_n  = MACK;
            end else begin
              tx_n     = {tx_r[6:0], 1'b0};
              sda_lo_n = tx_r[6];
              cnt_n    = cnt_r + 4'd1;
            end
          end else begin
            state_n = state_r;
          end
        end
        MACK: begin
          if (scl_rise_s) begin
            done_n = 1'b1;
            if (!sda_s) begin
              tx_n    = din;
              state_n = TX;
            end else begin
              ack_err_n = 1'b1;
              state_n   = WAIT_STOP;
            end
          end else begin
            state_n = state_r;
          end
        end
        WAIT_STOP: begin
          sda_oe_n = 1'b0;
          sda_lo_n = 1'b1;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          sda_lo_n = 1'b1;
        end
      endcase
    end
  end

  assign sda     = (sda_oe_r && !sda_lo_r) ? 1'b0 : 1'bz;
  assign dout    = dout_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign op      = op_r;
  assign ack_err = ack_err_r;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, done-pulse scoreboard, directed and
// randomized transactions checked against a transaction-level model.
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h50;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst, scl, m_low;
  logic [7:0] din, dout;
  logic busy, done, op, ack_err;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .din(din),
    .dout(dout), .busy(busy), .done(done), .op(op), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dout;
    logic       op;
    logic       ack_err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  logic [7:0] model_dout;
  logic [7:0] tdata [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got dout=%0h op=%0b ack_err=%0b, none expected", dout, op, ack_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dout, op, ack_err} !== mon_e) begin
          errors++;
          $display("FAIL done_record: got %0h/%0b/%0b expected %0h/%0b/%0b",
                   dout, op, ack_err, mon_e.dout, mon_e.op, mon_e.ack_err);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic drive_low, output logic sampled);
    m_low = drive_low;
    wait_q();
    scl = 1'b1;
    wait_q();
    sampled = sda;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b0;
    wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(!b[i], s);
    clock_bit(1'b0, s);
    acked = !s;
  endtask

  task automatic recv_byte(input logic nack, input logic [7:0] next_din, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, s);
      b[i] = s;
    end
    din = next_din;
    clock_bit(!nack, s);
  endtask

  // Address phase plus n data bytes from tdata; reads NACK the last byte
  task automatic xfer(input logic [6:0] a, input logic rd, input int n);
    logic acked;
    logic [7:0] got;
    logic match;
    match = (a == ADDR);
    if (rd) din = tdata[0];
    send_byte({a, rd}, acked);
    check("addr_ack", {31'd0, acked}, {31'd0, match});
    if (match) begin
      check("busy_after_addr", {31'd0, busy}, 32'd1);
      check("op", {31'd0, op}, {31'd0, rd});
      for (int k = 0; k < n; k++) begin
        if (rd) begin
          exp_q.push_back({model_dout, 1'b1, (k == n - 1)});
          recv_byte(k == n - 1, (k < n - 1) ? tdata[k+1] : 8'h00, got);
          check("rd_byte", {24'd0, got}, {24'd0, tdata[k]});
        end else begin
          exp_q.push_back({tdata[k], 1'b0, 1'b0});
          model_dout = tdata[k];
          send_byte(tdata[k], acked);
          check("wr_ack", {31'd0, acked}, 32'd1);
        end
      end
    end else begin
      check("busy_no_match", {31'd0, busy}, 32'd0);
    end
    check("pending_done", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic s;
    logic [6:0] ra;
    logic rrd;
    int rn;
    rst = 1'b1;
    scl = 1'b1;
    m_low = 1'b0;
    din = 8'h00;
    model_dout = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_op", {31'd0, op}, 32'd0);
    check("rst_ack_err", {31'd0, ack_err}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);

    // Write 0x3C
    i2c_start();
    tdata[0] = 8'h3C;
    xfer(ADDR, 1'b0, 1);
    i2c_stop();
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
    check("wr_dout", {24'd0, dout}, 32'h3C);

    // Read 0xA5 with master NACK
    i2c_start();
    tdata[0] = 8'hA5;
    xfer(ADDR, 1'b1, 1);
    i2c_stop();
    check("rd_ack_err", {31'd0, ack_err}, 32'd1);
    check("rd_op", {31'd0, op}, 32'd1);
    check("rd_busy_after_stop", {31'd0, busy}, 32'd0);

    // Wrong address 0xB0
    i2c_start();
    xfer(7'h58, 1'b0, 1);
    check("wa_ack_err_cleared", {31'd0, ack_err}, 32'd0);
    i2c_stop();
    check("wa_dout", {24'd0, dout}, 32'h3C);

    // Repeated start: write 0x11 then read 0x5A
    i2c_start();
    tdata[0] = 8'h11;
    xfer(ADDR, 1'b0, 1);
    i2c_start();
    check("rs_busy_kept", {31'd0, busy}, 32'd1);
    tdata[0] = 8'h5A;
    xfer(ADDR, 1'b1, 1);
    i2c_stop();
    check("rs_dout", {24'd0, dout}, 32'h11);

    // Abort after 4 data bits, then a full write of 0x77
    i2c_start();
    xfer(ADDR, 1'b0, 0);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    i2c_stop();
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_dout", {24'd0, dout}, 32'h11);
    check("ab_no_done", exp_q.size(), 32'd0);
    i2c_start();
    tdata[0] = 8'h77;
    xfer(ADDR, 1'b0, 1);
    i2c_stop();
    check("ab_dout_after", {24'd0, dout}, 32'h77);

    // Reset while the slave holds the address ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(!((8'hA0 >> i) & 8'h01), s);
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    check("rst_ack_held", {31'd0, sda}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_sda_released", {31'd0, sda}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_dout = 8'h00;
    @(negedge clk);
    check("rst2_dout", {24'd0, dout}, 32'd0);
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_op", {31'd0, op}, 32'd0);
    check("rst2_ack_err", {31'd0, ack_err}, 32'd0);
    scl = 1'b0;
    wait_q();
    i2c_stop();

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      if ($urandom_range(0, 3) != 0) ra = ADDR;
      else begin
        ra = 7'($urandom_range(0, 127));
        if (ra == ADDR) ra = ADDR ^ 7'h01;
      end
      rrd = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 3);
      for (int k = 0; k < 3; k++) tdata[k] = 8'($urandom_range(0, 255));
      i2c_start();
      xfer(ra, rrd, rn);
      i2c_stop();
      check("rnd_busy", {31'd0, busy}, 32'd0);
      check("rnd_dout", {24'd0, dout}, {24'd0, model_dout});
      check("rnd_sda_idle", {31'd0, sda}, 32'd1);
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address the block responds to.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of flops in the synchronizer on each of scl and sda.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  system clock (40 MHz nominal).
- rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have these remaining ports:
- scl  input  1  bus clock from the master.
- sda  inout  1  bus data; the block drives only 0 or z.
- din  input  8  byte returned on a read; sampled at the address ACK.
- dout  output  8  last byte written by the master.
- busy  output  1  high from an addressed START until STOP or abort.
- done  output  1  one-clk pulse at the end of each completed data byte (after its ACK bit).
- op  output  1  R/W bit captured from the matched address byte (1 = read).
- ack_err  output  1  set when the master NACKs a read byte; cleared at the next START.

Function
REQ-005 scl and sda SHALL pass through SYNC_STAGES flops; all edge detection SHALL use the synchronized values.
REQ-006 Bus events SHALL be detected as follows:
- START: sda falls while scl is high.
- STOP: sda rises while scl is high.
- scl_rise and scl_fall: single-clk strobes.
REQ-007 SDA SHALL be open-drain: sda = 0 when sda_oe is high and sda_lo is low, z otherwise; it SHALL never be driven to 1.
REQ-008 Received bits SHALL be shifted in MSB first on scl_rise.
REQ-009 The sda drive value SHALL change only on scl_fall, and SHALL take effect within SYNC_STAGES+2 clk of the scl pin falling.
REQ-010 The state machine SHALL have the states IDLE, ADDR, ACK_A, RX, ACK_D, TX, MACK and WAIT_STOP.
REQ-011 IDLE SHALL go to ADDR on START, clearing the bit counter and ack_err.
REQ-012 ADDR SHALL shift in 8 bits; on the 8th scl_rise it SHALL compare bits [7:1] with SLAVE_ADDR.
- Match: go to ACK_A, latch op = bit0, set busy.
- Mismatch: go to WAIT_STOP with no drive.
REQ-013 ACK_A SHALL pull sda low from the next scl_fall until the following scl_fall.
- At that release, with op=0: go to RX.
- At that release, with op=1: latch din into the transmit shift register, drive its bit7 and go to TX.
REQ-014 RX SHALL shift in 8 bits; after the 8th it SHALL load dout and go to ACK_D.
REQ-015 ACK_D SHALL drive ACK exactly as ACK_A, pulse done at the releasing scl_fall, and then return to RX for the next byte.
REQ-016 TX SHALL present one bit per scl_fall, MSB first, with a 1 bit released (z); after the 8th bit's scl_fall the block SHALL release sda and go to MACK.
REQ-017 MACK SHALL sample sda on scl_rise and pulse done.
- sda=0 (ACK): re-latch din and go to TX.
- sda=1 (NACK): set ack_err and go to WAIT_STOP.
REQ-018 WAIT_STOP SHALL release sda and wait for START or STOP.
REQ-019 STOP in any state SHALL return the block to IDLE, release sda and clear busy within 1 clk of detection.
REQ-020 START in any non-IDLE state (repeated start) SHALL go to ADDR, reset the bit counter and keep busy.
REQ-021 A STOP or START in the middle of a byte SHALL abort that byte: dout unchanged, no done pulse.
REQ-022 START and STOP detection SHALL take priority over scl edge handling in the same clk.
REQ-023 The bit counter SHALL be 4 bits and count 0..7; it SHALL never wrap while in ACK states.

Reset
REQ-024 On rst the block SHALL set state=IDLE, sda_oe=0 (sda = z), dout=8'h00, busy=0, done=0, op=0, ack_err=0, shift registers=0, and the synchronizer flops to 1.
REQ-025 rst asserted mid-transaction SHALL release sda on the next clk, and the block SHALL ignore the bus until the next START.

Verification
REQ-026 Write: START, 0xA0 (addr 0x50, W), 0x3C, STOP -> ACK on both bytes; dout=0x3C; one done pulse; busy falls after STOP.
REQ-027 Read: din=0xA5; START, 0xA1, master NACK, STOP -> bits 1,0,1,0,0,1,0,1 on sda; op=1; ack_err=1; done pulses once.
REQ-028 Wrong address: START, 0xB0 -> sda stays z through the ACK slot; busy stays 0; dout unchanged.
REQ-029 Repeated start: START, 0xA0, 0x11, START, 0xA1 (din=0x5A), NACK, STOP -> dout=0x11; then 0x5A transmitted.
REQ-030 Abort: STOP after 4 bits of a data byte -> state IDLE, dout unchanged, no done; a following full write of 0x77 succeeds.
REQ-031 Reset: rst asserted while the slave holds ACK low -> sda is z on the next clk; all outputs are at their reset values.
